// File: rtl/net_trainer.sv
`default_nettype none
// ============================================================================
// Module      : net_trainer
// Description : Training-loop controller for a layered network. It accepts a
//               labelled sample, starts the forward pass, computes the
//               saturated loss gradient (target - output) one output per
//               cycle while tracking the argmax, starts the backward pass and
//               reports prediction and accuracy status on completion.
//               Optional feature macro: NET_TRAINER_ERR_ACCUM_EN adds a
//               saturating absolute-error accumulator on err_accum.
// Revision    : 1.0 - initial release
// ============================================================================
module net_trainer #(
  parameter int INT_W    = 9,
  parameter int FRAC_W   = 8,
  parameter int NUM_W    = INT_W + FRAC_W,
  parameter int OUTPUTS  = 2,
  parameter int RELU_MAX = 1,
  parameter int LABEL_W  = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [LABEL_W-1:0]      label,
  output logic                    start_f,
  output logic                    start_b,
  input  logic                    net_ready,
  input  logic signed [NUM_W-1:0] outputs_in   [OUTPUTS],
  output logic signed [NUM_W-1:0] outputs_diff [OUTPUTS],
  output logic                    done,
  output logic [LABEL_W-1:0]      pred,
  output logic                    correct,
  output logic                    label_err,
  output logic [31:0]             sample_count,
  output logic [2*NUM_W-1:0]      err_accum,
  input  logic                    err_clear
);

  // Width of the per-output loss index.
  localparam int K_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  // Target value for the labelled output, held at the widened subtraction width.
  localparam logic [NUM_W:0] TARGET = (NUM_W+1)'(RELU_MAX) << FRAC_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FWD_START = 3'd1,
    FWD_WAIT  = 3'd2,
    LOSS      = 3'd3,
    BWD_START = 3'd4,
    BWD_WAIT  = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t                    state;
  state_t                    state_nxt;

  // Set once the settle cycle after a start pulse has been consumed; net_ready
  // is only trusted after that because the layers drop ready one cycle late.
  logic                      settle_done;
  logic [K_W-1:0]            k_idx;
  logic [LABEL_W-1:0]        label_q;
  logic                      label_bad_q;
  logic signed [NUM_W-1:0]   max_val;
  logic [LABEL_W-1:0]        max_idx;

  logic                      accept;
  logic                      label_bad;
  logic                      k_last;
  logic                      target_hit;
  logic                      finish_bwd;
  logic signed [NUM_W-1:0]   cur_in;
  logic [NUM_W:0]            diff_wide;
  logic [NUM_W-1:0]          diff_sat;

  assign accept     = (state == IDLE) && sample_valid && net_ready;
  assign label_bad  = (32'(label) >= 32'(OUTPUTS));
  assign k_last     = (k_idx == K_W'(OUTPUTS - 1));
  assign target_hit = !label_bad_q && (32'(k_idx) == 32'(label_q));
  assign finish_bwd = (state == BWD_WAIT) && (state_nxt == DONE);
  assign cur_in     = outputs_in[k_idx];

  // One extra bit of headroom so the subtraction cannot wrap before saturation.
  assign diff_wide  = (target_hit ? TARGET : '0) - {cur_in[NUM_W-1], cur_in};

  // Clamp the widened difference back to the signed number range.
  always_comb begin
    if (diff_wide[NUM_W] != diff_wide[NUM_W-1]) begin
      diff_sat = diff_wide[NUM_W] ? {1'b1, {(NUM_W-1){1'b0}}}
                                  : {1'b0, {(NUM_W-1){1'b1}}};
    end else begin
      diff_sat = diff_wide[NUM_W-1:0];
    end
  end

  // State register; the whole controller freezes while enable is low.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  // Next-state decode and Moore-style control outputs.
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    start_f      = 1'b0;
    start_b      = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        sample_ready = net_ready;
        if (sample_valid && net_ready) state_nxt = FWD_START;
      end
      FWD_START: begin
        start_f   = 1'b1;
        state_nxt = FWD_WAIT;
      end
      FWD_WAIT: begin
        if (settle_done && net_ready) state_nxt = LOSS;
      end
      LOSS: begin
        if (k_last) state_nxt = BWD_START;
      end
      BWD_START: begin
        start_b   = 1'b1;
        state_nxt = BWD_WAIT;
      end
      BWD_WAIT: begin
        if (settle_done && net_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sequencing registers: latched label, settle flag, loss index and argmax.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      settle_done <= 1'b0;
      k_idx       <= '0;
      label_q     <= '0;
      label_bad_q <= 1'b0;
      max_val     <= '0;
      max_idx     <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (accept) begin
            label_q     <= label;
            label_bad_q <= label_bad;
          end
        end
        FWD_START: begin
          settle_done <= 1'b0;
          k_idx       <= '0;
        end
        FWD_WAIT, BWD_WAIT: begin
          settle_done <= 1'b1;
        end
        LOSS: begin
          k_idx <= k_last ? '0 : k_idx + K_W'(1);
          // Strictly-greater replacement keeps the lowest index on ties.
          if ((k_idx == '0) || (cur_in > max_val)) begin
            max_val <= cur_in;
            max_idx <= LABEL_W'(k_idx);
          end
        end
        BWD_START: begin
          settle_done <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Loss gradient registers; each is written once per sample and then held
  // so the backward pass sees a stable value.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < OUTPUTS; i++) outputs_diff[i] <= '0;
    end else if (enable && (state == LOSS)) begin
      outputs_diff[k_idx] <= diff_sat;
    end
  end

  // Per-sample status, published as the controller enters DONE so it is
  // already valid alongside the done pulse.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pred         <= '0;
      correct      <= 1'b0;
      label_err    <= 1'b0;
      sample_count <= '0;
    end else if (enable) begin
      if (accept) begin
        label_err <= 1'b0;
      end
      if (finish_bwd) begin
        pred         <= max_idx;
        correct      <= !label_bad_q && (max_idx == label_q);
        label_err    <= label_bad_q;
        sample_count <= sample_count + 32'd1;
      end
    end
  end

`ifdef NET_TRAINER_ERR_ACCUM_EN
  logic [NUM_W-1:0]   abs_diff;
  logic [2*NUM_W:0]   acc_sum;

  // Magnitude of the gradient being written; the most negative value maps to
  // 2^(NUM_W-1), which still fits as an unsigned NUM_W quantity.
  always_comb begin
    abs_diff = diff_sat[NUM_W-1] ? (~diff_sat + NUM_W'(1)) : diff_sat;
    acc_sum  = {1'b0, err_accum} + {{(NUM_W+1){1'b0}}, abs_diff};
  end

  // Saturating error accumulator; a clear overrides a coincident add.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_accum <= '0;
    end else if (enable) begin
      if (err_clear) begin
        err_accum <= '0;
      end else if (state == LOSS) begin
        err_accum <= acc_sum[2*NUM_W] ? '1 : acc_sum[2*NUM_W-1:0];
      end
    end
  end
`else
  logic unused_err_clear;

  assign err_accum        = '0;
  assign unused_err_clear = err_clear;
`endif

endmodule
`default_nettype wire

// File: tb/tb_net_trainer.sv
`default_nettype none
module tb_net_trainer;
  localparam int INT_W    = 9;
  localparam int FRAC_W   = 8;
  localparam int NUM_W    = INT_W + FRAC_W;
  localparam int OUTPUTS  = 2;
  localparam int LABEL_W  = 2;   // wide enough to offer labels 2 and 3
  localparam int RELU_MAX = 1;

  localparam longint SMAX = (longint'(1) << (NUM_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (NUM_W - 1));
  localparam longint AMAX = (longint'(1) << (2 * NUM_W)) - 1;

  typedef logic [OUTPUTS-1:0][NUM_W-1:0] vec_t;
  typedef struct packed {
    vec_t                 diff;
    logic [LABEL_W-1:0]   pred;
    logic                 correct;
    logic                 label_err;
    logic [31:0]          count;
    logic [2*NUM_W-1:0]   acc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    nreset = 1'b0;
  logic                    enable = 1'b0;
  logic                    sample_valid = 1'b0;
  logic                    sample_ready;
  logic [LABEL_W-1:0]      label = '0;
  logic                    start_f;
  logic                    start_b;
  logic                    net_ready = 1'b1;
  logic signed [NUM_W-1:0] outputs_in   [OUTPUTS];
  logic signed [NUM_W-1:0] outputs_diff [OUTPUTS];
  logic                    done;
  logic [LABEL_W-1:0]      pred;
  logic                    correct;
  logic                    label_err;
  logic [31:0]             sample_count;
  logic [2*NUM_W-1:0]      err_accum;
  logic                    err_clear = 1'b0;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  longint m_count = 0;
  longint m_acc = 0;
  vec_t   cur_in = '0;
  bit     clear_test = 1'b0;
  bit     force_en = 1'b0;
  bit     acc_flag = 1'b0;
  bit     b_consumed = 1'b0;
  int     hold = 0;

  net_trainer #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .NUM_W(NUM_W), .OUTPUTS(OUTPUTS),
    .RELU_MAX(RELU_MAX), .LABEL_W(LABEL_W)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .label(label),
    .start_f(start_f), .start_b(start_b), .net_ready(net_ready),
    .outputs_in(outputs_in), .outputs_diff(outputs_diff), .done(done),
    .pred(pred), .correct(correct), .label_err(label_err),
    .sample_count(sample_count), .err_accum(err_accum), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: gradient = clamp(target - output), argmax with lowest index on ties.
  function automatic exp_t model(input int lbl, input vec_t vin, input bit clr);
    exp_t   e;
    longint x, t, d, maxv, sum_all, sum_tail;
    int     best;
    e = '0; sum_all = 0; sum_tail = 0; maxv = 0; best = 0;
    for (int k = 0; k < OUTPUTS; k++) begin
      x = longint'($signed(vin[k]));
      t = (k == lbl) ? (longint'(RELU_MAX) << FRAC_W) : 0;
      d = t - x;
      if (d > SMAX) d = SMAX;
      if (d < SMIN) d = SMIN;
      e.diff[k] = NUM_W'(d);
      sum_all += (d < 0) ? -d : d;
      if (k > 0) sum_tail += (d < 0) ? -d : d;
      if (k == 0 || x > maxv) begin
        maxv = x;
        best = k;
      end
    end
    e.pred      = LABEL_W'(best);
    e.correct   = (lbl < OUTPUTS) && (best == lbl);
    e.label_err = (lbl >= OUTPUTS);
    m_count     = (m_count + 1) & 64'hFFFF_FFFF;
    e.count     = 32'(m_count);
`ifdef NET_TRAINER_ERR_ACCUM_EN
    m_acc = clr ? sum_tail : m_acc + sum_all;
    if (m_acc > AMAX) m_acc = AMAX;
`else
    m_acc = 0;
`endif
    e.acc = (2*NUM_W)'(m_acc);
    return e;
  endfunction

  // Network stand-in plus enable generator: ready stays high through the
  // settle edge, drops for a busy period, then returns with the results.
  initial begin : env
    int phase, busy;
    bit fwd, p_sf, p_sb, p_en, clr_pending;
    phase = 0; busy = 0; fwd = 0; p_sf = 0; p_sb = 0; p_en = 0; clr_pending = 0;
    for (int k = 0; k < OUTPUTS; k++) outputs_in[k] = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        phase = 0; net_ready = 1'b1; p_sf = 0; p_sb = 0; p_en = 0;
        clr_pending = 0; err_clear = 1'b0; acc_flag = 1'b0; enable = 1'b1;
        continue;
      end
      err_clear = clr_pending;
      clr_pending = 0;
      if (p_sf && p_en) begin
        phase = 1; fwd = 1;
        for (int k = 0; k < OUTPUTS; k++) outputs_in[k] = NUM_W'($urandom);
      end else if (p_sb && p_en) begin
        phase = 1; fwd = 0;
      end else if (phase == 1) begin
        phase = 2; net_ready = 1'b0;
        busy = (hold > 0) ? hold : int'($urandom_range(1, 6));
      end else if (phase == 2) begin
        busy--;
        if (busy == 0) begin
          phase = 0; net_ready = 1'b1;
          if (fwd) begin
            for (int k = 0; k < OUTPUTS; k++) outputs_in[k] = cur_in[k];
            if (clear_test) clr_pending = 1;
          end
        end
      end
      enable = force_en ? 1'b1 : ($urandom_range(0, 99) < 85);
      #1;
      p_sf = start_f; p_sb = start_b; p_en = enable;
      acc_flag = sample_valid && sample_ready && enable;
    end
  end

  // Monitor: pops the scoreboard on every qualified done pulse.
  initial begin : monitor
    exp_t e;
    bit   in_flight;
    int   nf, nb;
    logic [NUM_W-1:0] dv;
    in_flight = 0; nf = 0; nb = 0;
    forever begin
      @(negedge clk); #2;
      if (!nreset) begin
        in_flight = 0; nf = 0; nb = 0;
        continue;
      end
      chk("dual_start", 64'(start_f && start_b), 0);
      if (in_flight) chk("ready_while_busy", 64'(sample_ready), 0);
      if (acc_flag) in_flight = 1;
      if (enable && start_f) nf++;
      if (enable && start_b) begin
        chk("start_b_after_start_f", 64'(nf), 1);
        nb++;
        b_consumed = 1'b1;
      end
      if (enable && done) begin
        in_flight = 0;
        chk("start_f_count", 64'(nf), 1);
        chk("start_b_count", 64'(nb), 1);
        nf = 0; nb = 0;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          for (int k = 0; k < OUTPUTS; k++) begin
            dv = outputs_diff[k];
            chk($sformatf("outputs_diff%0d", k), 64'(dv), 64'(e.diff[k]));
          end
          chk("pred", 64'(pred), 64'(e.pred));
          chk("correct", 64'(correct), 64'(e.correct));
          chk("label_err", 64'(label_err), 64'(e.label_err));
          chk("sample_count", 64'(sample_count), 64'(e.count));
          chk("err_accum", 64'(err_accum), 64'(e.acc));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    logic [NUM_W-1:0] dv;
    chk({tag, "_start_f"}, 64'(start_f), 0);
    chk({tag, "_start_b"}, 64'(start_b), 0);
    chk({tag, "_done"}, 64'(done), 0);
    for (int k = 0; k < OUTPUTS; k++) begin
      dv = outputs_diff[k];
      chk($sformatf("%s_diff%0d", tag, k), 64'(dv), 0);
    end
    chk({tag, "_pred"}, 64'(pred), 0);
    chk({tag, "_correct"}, 64'(correct), 0);
    chk({tag, "_label_err"}, 64'(label_err), 0);
    chk({tag, "_sample_count"}, 64'(sample_count), 0);
    chk({tag, "_err_accum"}, 64'(err_accum), 0);
  endtask

  task automatic issue(input int lbl, input vec_t vin, input bit clr, output bit ok);
    @(negedge clk);
    cur_in = vin; clear_test = clr; force_en = clr;
    label = LABEL_W'(lbl); sample_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (acc_flag) begin
        ok = 1;
        break;
      end
    end
    sample_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input int lbl, input vec_t vin, input bit clr);
    bit ok;
    issue(lbl, vin, clr, ok);
    if (ok) begin
      sb.push_back(model(lbl, vin, clr));
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        chk("done_timeout", 0, 1);
        sb.delete();
      end
    end
    clear_test = 0; force_en = 0;
  endtask

  initial begin : timeout
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t v;
    int   lbl;
    bit   ok;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    nreset = 1'b1;

    v[0] = 17'h00080; v[1] = 17'h00040;
    send(1, v, 0);
    send(1, v, 0);
    v[0] = 17'h0FFFF; v[1] = 17'h10000;
    send(1, v, 0);
    v[0] = 17'h00100; v[1] = 17'h1FF00;
    send(3, v, 0);
    v[0] = 17'h00040; v[1] = 17'h00040;
    send(2, v, 0);
    send(1, v, 0);
    v[0] = 17'h00080; v[1] = 17'h00040;
    send(1, v, 1);
    hold = 50;
    v[0] = 17'h1FF80; v[1] = 17'h00300;
    send(0, v, 0);
    hold = 0;

    for (int n = 0; n < 20; n++) begin
      lbl = int'($urandom_range(0, 3));
      for (int k = 0; k < OUTPUTS; k++) begin
        case ($urandom_range(0, 3))
          0:       v[k] = 17'h0FFFF;
          1:       v[k] = 17'h10000;
          default: v[k] = NUM_W'($urandom);
        endcase
      end
      send(lbl, v, 0);
    end

    // Reset while the backward pass is outstanding.
    hold = 20;
    b_consumed = 1'b0;
    v[0] = 17'h00010; v[1] = 17'h00020;
    issue(1, v, 0, ok);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_consumed) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("bwd_wait_timeout", 0, 1);
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    #1 check_zero("midpass_reset");
    hold = 0; m_count = 0; m_acc = 0;
    clear_test = 0; force_en = 0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    v[0] = 17'h00020; v[1] = 17'h00180;
    send(0, v, 0);

    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/net_trainer.md
NET_TRAINER -- requirements
Module: net_trainer

Interface
REQ-001 Parameters (name, default, meaning): INT_W, 9, integer bits; FRAC_W, 8, fraction bits; NUM_W, INT_W+FRAC_W, number width; OUTPUTS, 2, network output count; RELU_MAX, 1, integer target value for the labelled output; LABEL_W, $clog2(OUTPUTS) (min 1), label width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- nreset, in, 1, asynchronous active-low reset.
- enable, in, 1, global advance qualifier.
- sample_valid, in, 1, sample offered.
- sample_ready, out, 1, controller can accept a sample.
- label, in, LABEL_W, target class.
- start_f, out, 1, forward-pass start pulse.
- start_b, out, 1, backward-pass start pulse.
- net_ready, in, 1, wand of all layer ready_out signals.
- outputs_in, in, NUM_W signed x OUTPUTS, last-layer forward results.
- outputs_diff, out, NUM_W signed x OUTPUTS, registered loss gradient to the last layer.
- done, out, 1, one-cycle end-of-sample pulse.
- pred, out, LABEL_W, argmax class.
- correct, out, 1, pred equals label.
- label_err, out, 1, label >= OUTPUTS.
- sample_count, out, 32, completed samples.
- err_accum, out, 2*NUM_W, accumulated absolute error.
- err_clear, in, 1, clears err_accum.

Function
REQ-003 States: IDLE, FWD_START, FWD_WAIT, LOSS, BWD_START, BWD_WAIT, DONE.
REQ-004 All state and registers advance only when enable=1; with enable=0 everything holds, including pulse outputs.
REQ-005 sample_ready=1 only in IDLE, and only while net_ready=1.
REQ-006 IDLE: on sample_valid && sample_ready, latch label, then go to FWD_START.
REQ-007 FWD_START: drive start_f=1 for exactly one cycle, then go to FWD_WAIT.
REQ-008 FWD_WAIT: ignore net_ready on the first cycle after the pulse (settle cycle). Afterwards go to LOSS on the first cycle with net_ready=1.
REQ-009 LOSS: compute one output per cycle, k=0..OUTPUTS-1 (OUTPUTS cycles total).
- outputs_diff[k] = sat_NUM_W(T_k - outputs_in[k]).
- T_k = RELU_MAX<<FRAC_W when k==label, else 0.
- Subtraction is done at NUM_W+1 bits, then saturated to [-2^(NUM_W-1), 2^(NUM_W-1)-1].
REQ-010 LOSS also tracks the argmax. A strictly greater value replaces the current maximum, so the lowest index wins ties.
REQ-011 BWD_START: drive start_b=1 for exactly one cycle. BWD_WAIT: one settle cycle, then wait for net_ready=1 and go to DONE.
REQ-012 DONE (one cycle):
- done=1.
- pred and correct update and hold until the next DONE.
- sample_count increments, wrapping 2^32-1 -> 0.
- Next state is IDLE.
REQ-013 outputs_diff holds its value from LOSS until the next LOSS writes it, so it is stable throughout the backward pass.
REQ-014 label >= OUTPUTS:
- All targets are 0.
- label_err=1 from DONE until the next accepted sample.
- correct=0.
REQ-015 start_f and start_b are never asserted in the same cycle; each is asserted at most once per sample.
REQ-016 Latency per sample = 1 accept + 1 start_f + settle + forward wait + OUTPUTS + 1 start_b + settle + backward wait + 1 done.

Reset
REQ-017 nreset=0, at any time including mid-pass, immediately sets:
- state=IDLE.
- start_f=start_b=done=0.
- outputs_diff all 0.
- pred=0, correct=0, label_err=0.
- sample_count=0, err_accum=0.
REQ-018 After release, the first accepted sample begins a fresh sequence; no partial pass resumes.

Configuration
REQ-019 Macro NET_TRAINER_ERR_ACCUM_EN.
- When defined: each LOSS cycle adds |outputs_diff[k]|, zero-extended to 2*NUM_W, to err_accum, saturating at 2^(2*NUM_W)-1. err_clear=1 (qualified by enable) zeroes err_accum; if an add occurs in the same cycle, clear wins.
- When undefined: err_accum is tied to 0, err_clear is ignored, and no accumulator logic exists.

Verification
REQ-020 Happy path, OUTPUTS=2, label=1, outputs_in={0x0080, 0x0040}:
- outputs_diff={0x1FF80, 0x000C0}.
- pred=0, correct=0, done pulses once.
- sample_count=1.
REQ-021 Saturation: outputs_in[0]=0x0FFFF (most positive), label=1 -> outputs_diff[0]=0x10001. outputs_in[1]=0x10000 (most negative), label=1 -> outputs_diff[1] saturates to 0x0FFFF.
REQ-022 Handshake: net_ready held 0 for 50 cycles after start_f -> no start_b and no LOSS until net_ready=1; start_f seen exactly once; sample_ready=0 throughout.
REQ-023 Reset mid-BWD_WAIT -> all outputs zero at once; the next sample yields start_f with no stray start_b.
REQ-024 Invalid label=3 with OUTPUTS=2 -> outputs_diff[k] = -outputs_in[k], label_err=1, correct=0.
REQ-025 With NET_TRAINER_ERR_ACCUM_EN: two samples as in REQ-020 -> err_accum=0x280. With err_clear asserted during LOSS -> the clear takes effect that cycle and only subsequent adds accumulate.
